// File: rtl/issue_queue_entry_allocator.sv
// Free-list allocator for issue-queue entries.
// A circular FIFO holds the free IQ indices. Dispatch takes up to
// ALLOC_WIDTH indices from the head, and issue/squash returns up to
// RELEASE_WIDTH indices at the tail. The occupancy counter tells a full
// list from an empty one when head == tail.
//
// Handshake: allocReq is the per-lane valid and canAllocate is the ready.
// A lane is taken only in a cycle where it is valid and canAllocate is 1.
// Allocation is all-or-nothing: when canAllocate is 0, no lane is accepted.
// Upstream must not raise allocReq while canAllocate is 0.
// releaseValid has no ready; every strobed lane is taken unconditionally.
module issue_queue_entry_allocator #(
    parameter int ENTRY_NUM     = 16,
    parameter int INDEX_WIDTH   = 4,
    parameter int ALLOC_WIDTH   = 2,
    parameter int RELEASE_WIDTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,
    input  logic [ALLOC_WIDTH-1:0]               allocReq,
    output logic [ALLOC_WIDTH*INDEX_WIDTH-1:0]   allocPtr,
    output logic                                 canAllocate,
    input  logic [RELEASE_WIDTH-1:0]             releaseValid,
    input  logic [RELEASE_WIDTH*INDEX_WIDTH-1:0] releasePtr,
    output logic [INDEX_WIDTH:0]                 freeCount
);

    // Wide enough to hold count + RELEASE_WIDTH without wrapping,
    // so a double free shows up as a value above ENTRY_NUM.
    localparam int CW = INDEX_WIDTH + 2;

    localparam logic [INDEX_WIDTH:0] ALLOC_W_C   = ALLOC_WIDTH[INDEX_WIDTH:0];
    localparam logic [INDEX_WIDTH:0] ENTRY_NUM_C = ENTRY_NUM[INDEX_WIDTH:0];
    localparam logic [CW-1:0]        ENTRY_NUM_W = ENTRY_NUM[CW-1:0];
    localparam logic [CW-1:0]        ONE_W       = {{(CW-1){1'b0}}, 1'b1};

    logic [INDEX_WIDTH-1:0] fifo      [ENTRY_NUM];
    logic [INDEX_WIDTH-1:0] fifo_next [ENTRY_NUM];
    logic [INDEX_WIDTH-1:0] head, head_next;
    logic [INDEX_WIDTH-1:0] tail, tail_next;
    logic [INDEX_WIDTH:0]   count, count_next;
    logic [CW-1:0]          n_alloc, n_release, count_sum;
    logic [ALLOC_WIDTH-1:0] alloc_plus1;

    // Pointer arithmetic wraps naturally at ENTRY_NUM (a power of two).
    function automatic logic [INDEX_WIDTH-1:0] wrap_add(
        input logic [INDEX_WIDTH-1:0] base,
        input logic [INDEX_WIDTH-1:0] off
    );
        return base + off;
    endfunction

    // Drive the outputs from registered state only, so an index released this cycle is not offered until the next one.
    always_comb begin
        allocPtr    = '0;
        canAllocate = (count >= ALLOC_W_C);
        freeCount   = count;
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            allocPtr[i*INDEX_WIDTH +: INDEX_WIDTH] = fifo[wrap_add(head, i[INDEX_WIDTH-1:0])];
        end
    end

    // Next state: pop accepted lanes at head, then append the released indices in ascending lane order at tail.
    always_comb begin
        n_alloc   = '0;
        n_release = '0;
        fifo_next = fifo;
        if (canAllocate) begin
            for (int i = 0; i < ALLOC_WIDTH; i++) begin
                n_alloc = n_alloc + {{(CW-1){1'b0}}, allocReq[i]};
            end
        end
        for (int j = 0; j < RELEASE_WIDTH; j++) begin
            if (releaseValid[j]) begin
                fifo_next[wrap_add(tail, n_release[INDEX_WIDTH-1:0])] =
                    releasePtr[j*INDEX_WIDTH +: INDEX_WIDTH];
                n_release = n_release + ONE_W;
            end
        end
        head_next   = wrap_add(head, n_alloc[INDEX_WIDTH-1:0]);
        tail_next   = wrap_add(tail, n_release[INDEX_WIDTH-1:0]);
        count_sum   = {1'b0, count} + n_release - n_alloc;
        count_next  = count_sum[INDEX_WIDTH:0];
        alloc_plus1 = allocReq + {{(ALLOC_WIDTH-1){1'b0}}, 1'b1};
    end

    // State register: reset and flush both restore the identity free list, and flush wins over alloc/release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < ENTRY_NUM; k++) begin
                fifo[k] <= k[INDEX_WIDTH-1:0];
            end
            head  <= '0;
            tail  <= '0;
            count <= ENTRY_NUM_C;
        end else if (flush) begin
            for (int k = 0; k < ENTRY_NUM; k++) begin
                fifo[k] <= k[INDEX_WIDTH-1:0];
            end
            head  <= '0;
            tail  <= '0;
            count <= ENTRY_NUM_C;
        end else begin
            fifo  <= fifo_next;
            head  <= head_next;
            tail  <= tail_next;
            count <= count_next;
        end
    end

    // Protocol checks: no request without canAllocate, requests form a lane prefix, no double free.
    always_ff @(posedge clk) begin
        if (rst && !flush) begin
            a_alloc_when_empty: assert (allocReq == '0 || canAllocate);
            a_alloc_prefix:     assert ((alloc_plus1 & allocReq) == '0);
            a_double_free:      assert (count_sum <= ENTRY_NUM_W);
        end
    end

endmodule
